// File: rtl/soft_f_div_writer.sv
// rtl/soft_f_div_writer.sv - splits full-width words into DATA_DIV narrow memory writes
//
// Accepts one DATA_WIDTH word per w_en/ready handshake and writes it LSB slice
// first, one SLICE_W slice per cycle, to addresses addr_in*DATA_DIV + k.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_en, addr_in,      word write request (taken when ready=1), word address,
//   data_in             word data
//   ready               block accepts a word at the next rising edge
//   mem_we, mem_addr,   narrow memory write strobe, address, data
//   mem_data
//   done                pulse with the last slice of an in-range word
//   err                 pulse with the last slice cycle of an out-of-range word
module soft_f_div_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 64,
  parameter int DATA_DIV   = 4,
  localparam int SLICE_W        = DATA_WIDTH / DATA_DIV,
  localparam int ADDR_IN_WIDTH  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int MEM_ADDR_WIDTH = (DATA_DEPTH * DATA_DIV > 1) ? $clog2(DATA_DEPTH * DATA_DIV) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [ADDR_IN_WIDTH-1:0]  addr_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      ready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [SLICE_W-1:0]        mem_data,
  output logic                      done,
  output logic                      err
);

  localparam int CW = (DATA_DIV > 1) ? $clog2(DATA_DIV) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      bad_q, bad_d;

  logic                      ready_d, mem_we_d, done_d, err_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_d;
  logic [SLICE_W-1:0]        mem_data_d;

  logic accept;
  logic in_bad;
  logic last_slice;
  logic next_is_last;

  assign accept       = w_en && ready;
  assign in_bad       = 32'(addr_in) >= 32'(DATA_DEPTH);
  assign last_slice   = (32'(cnt_q) == 32'(DATA_DIV - 1));
  assign next_is_last = (32'(cnt_q) + 32'd1 == 32'(DATA_DIV - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    base_d     = base_q;
    bad_d      = bad_q;
    ready_d    = ready;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_data_d = mem_data;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (accept) begin
      // ready is only high in IDLE or in the last-slice cycle, so this branch
      // both starts a fresh word and chains a back-to-back word without a bubble.
      state_d = WRITE;
      cnt_d   = '0;
      word_d  = data_in;
      base_d  = MEM_ADDR_WIDTH'(addr_in) * MEM_ADDR_WIDTH'(DATA_DIV);
      bad_d   = in_bad;
      if (!in_bad) begin
        mem_we_d   = 1'b1;
        mem_addr_d = MEM_ADDR_WIDTH'(addr_in) * MEM_ADDR_WIDTH'(DATA_DIV);
        mem_data_d = data_in[SLICE_W-1:0];
      end
      ready_d = (DATA_DIV == 1);
      done_d  = (DATA_DIV == 1) && !in_bad;
      err_d   = (DATA_DIV == 1) && in_bad;
    end else if (state_q == WRITE && !last_slice) begin
      cnt_d  = cnt_q + CW'(1);
      // The held word is shifted so the next slice is always in the low bits.
      word_d = word_q >> SLICE_W;
      if (!bad_q) begin
        mem_we_d   = 1'b1;
        mem_addr_d = base_q + MEM_ADDR_WIDTH'(cnt_q) + MEM_ADDR_WIDTH'(1);
        mem_data_d = word_d[SLICE_W-1:0];
      end
      ready_d = next_is_last;
      done_d  = next_is_last && !bad_q;
      err_d   = next_is_last && bad_q;
    end else if (state_q == WRITE) begin
      state_d = IDLE;
      cnt_d   = '0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      base_q   <= '0;
      bad_q    <= 1'b0;
      ready    <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      base_q   <= base_d;
      bad_q    <= bad_d;
      ready    <= ready_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_data <= mem_data_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_soft_f_div_writer.sv
// tb/tb_soft_f_div_writer.sv - directed self-checking bench for soft_f_div_writer
module tb_soft_f_div_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // A: DATA_WIDTH=8, DATA_DIV=4, DATA_DEPTH=16
  logic       a_w_en = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_we, a_done, a_err;
  logic [5:0] a_maddr;
  logic [1:0] a_mdata;

  // B: DATA_WIDTH=8, DATA_DIV=4, DATA_DEPTH=12
  logic       b_w_en = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_we, b_done, b_err;
  logic [5:0] b_maddr;
  logic [1:0] b_mdata;

  // C: DATA_WIDTH=8, DATA_DIV=1, DATA_DEPTH=16
  logic       c_w_en = 1'b0;
  logic [3:0] c_addr = '0;
  logic [7:0] c_data = '0;
  logic       c_ready, c_we, c_done, c_err;
  logic [3:0] c_maddr;
  logic [7:0] c_mdata;

  soft_f_div_writer #(.DATA_WIDTH(8), .DATA_DEPTH(16), .DATA_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .w_en(a_w_en), .addr_in(a_addr), .data_in(a_data),
    .ready(a_ready), .mem_we(a_we), .mem_addr(a_maddr), .mem_data(a_mdata),
    .done(a_done), .err(a_err));

  soft_f_div_writer #(.DATA_WIDTH(8), .DATA_DEPTH(12), .DATA_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .w_en(b_w_en), .addr_in(b_addr), .data_in(b_data),
    .ready(b_ready), .mem_we(b_we), .mem_addr(b_maddr), .mem_data(b_mdata),
    .done(b_done), .err(b_err));

  soft_f_div_writer #(.DATA_WIDTH(8), .DATA_DEPTH(16), .DATA_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .w_en(c_w_en), .addr_in(c_addr), .data_in(c_data),
    .ready(c_ready), .mem_we(c_we), .mem_addr(c_maddr), .mem_data(c_mdata),
    .done(c_done), .err(c_err));

  // After this returns, outputs show the cycle that began at the edge just passed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    got = {a_ready, a_we, a_done, a_err, a_maddr, a_mdata};
    total++;
    if (got !== 12'b1000_000000_00)
      $display("FAIL reset_a got=%b want=%b", got, 12'b1000_000000_00);
    else passed++;
    total++;
    if ({b_ready, b_we, b_done, b_err} !== 4'b1000)
      $display("FAIL reset_b got=%b want=1000", {b_ready, b_we, b_done, b_err});
    else passed++;
  endtask

  task automatic test_single();
    logic [1:0]  exp_slice [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [10:0] got, want;
    a_w_en = 1'b1; a_addr = 4'd3; a_data = 8'hE4;
    tick();
    a_w_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got  = {a_we, a_maddr, a_mdata, a_done, a_ready};
      want = {1'b1, 6'(12 + k), exp_slice[k], k == 3, k == 3};
      total++;
      if (got !== want) $display("FAIL single_k%0d got=%b want=%b", k, got, want);
      else passed++;
      tick();
    end
    total++;
    if ({a_we, a_done, a_ready} !== 3'b001)
      $display("FAIL single_after got=%b want=001", {a_we, a_done, a_ready});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, want;
    a_w_en = 1'b1; a_addr = 4'd0; a_data = 8'hFF;
    tick();
    // Second word held while ready=0; it is only taken in the last-slice cycle.
    a_addr = 4'd15; a_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) a_w_en = 1'b0;
      got  = {a_we, a_maddr, a_mdata, a_done};
      want = {1'b1, (k < 4) ? 6'(k) : 6'(56 + k), (k < 4) ? 2'b11 : 2'b00, (k == 3) || (k == 7)};
      total++;
      if (got !== want) $display("FAIL b2b_k%0d got=%b want=%b", k, got, want);
      else passed++;
      tick();
    end
    total++;
    if ({a_we, a_done, a_ready} !== 3'b001)
      $display("FAIL b2b_after got=%b want=001", {a_we, a_done, a_ready});
    else passed++;
  endtask

  task automatic test_ignored();
    int writes = 0;
    logic [5:0] last_addr = '0;
    a_w_en = 1'b1; a_addr = 4'd5; a_data = 8'h1B;
    tick();
    a_addr = 4'd7; a_data = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) a_w_en = 1'b0;
      if (a_we) begin
        writes++;
        last_addr = a_maddr;
      end
      tick();
    end
    total++;
    if (writes !== 4) $display("FAIL ignored_count got=%0d want=4", writes);
    else passed++;
    total++;
    if (last_addr !== 6'd23) $display("FAIL ignored_last_addr got=%0d want=23", last_addr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    a_w_en = 1'b1; a_addr = 4'd2; a_data = 8'hA5;
    tick();
    a_w_en = 1'b0;
    total++;
    if ({a_we, a_maddr, a_mdata} !== {1'b1, 6'd8, 2'b01})
      $display("FAIL rstmid_first got=%b want=%b", {a_we, a_maddr, a_mdata}, {1'b1, 6'd8, 2'b01});
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({a_we, a_done, a_err, a_ready} !== 4'b0001)
        $display("FAIL rstmid_c%0d got=%b want=0001", k, {a_we, a_done, a_err, a_ready});
      else passed++;
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic [9:0] got, want;
    b_w_en = 1'b1; b_addr = 4'd13; b_data = 8'h5A;
    tick();
    b_w_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got  = {b_we, b_err, b_done, b_ready, b_maddr};
      want = {1'b0, k == 3, 1'b0, k == 3, 6'd0};
      total++;
      if (got !== want) $display("FAIL oob_k%0d got=%b want=%b", k, got, want);
      else passed++;
      tick();
    end
    total++;
    if ({b_we, b_err, b_ready} !== 3'b001)
      $display("FAIL oob_after got=%b want=001", {b_we, b_err, b_ready});
    else passed++;
  endtask

  task automatic test_sweep_div1();
    logic [7:0] shadow [16];
    int bad_cycles = 0;
    int mism = 0;
    for (int j = 0; j < 16; j++) shadow[j] = 8'hEE;
    c_w_en = 1'b1; c_addr = 4'd0; c_data = 8'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!(c_ready && c_we && c_done && !c_err)) bad_cycles++;
      if (c_we) shadow[c_maddr] = c_mdata;
      c_addr = 4'(i + 1); c_data = 8'(i + 1);
      if (i == 15) c_w_en = 1'b0;
    end
    total++;
    if (bad_cycles !== 0) $display("FAIL sweep_every_cycle got=%0d bad cycles want=0", bad_cycles);
    else passed++;
    for (int j = 0; j < 16; j++) if (shadow[j] !== 8'(j)) mism++;
    total++;
    if (mism !== 0) $display("FAIL sweep_shadow got=%0d mismatching entries want=0", mism);
    else passed++;
    tick();
    total++;
    if ({c_we, c_ready} !== 2'b01) $display("FAIL sweep_after got=%b want=01", {c_we, c_ready});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_out_of_range();
    test_sweep_div1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
